// File: rtl/button_conditioner.sv
// Push-button front-end: 2-FF synchronizer, debounce FSM with hold timer,
// registered level, rise/fall/long pulses and a wrapping press counter.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 60000,
  parameter int unsigned HOLD_CYCLES     = 12000000,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw,
  output logic       btn_level,
  output logic       btn_rise,
  output logic       btn_fall,
  output logic       btn_long,
  output logic [7:0] press_cnt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ARMING    = 2'd1;
  localparam logic [1:0] PRESSED   = 2'd2;
  localparam logic [1:0] DISARMING = 2'd3;

  logic          s1_reg, s2_reg;
  logic [1:0]    state_reg, state_next;
  logic [DW-1:0] dcnt_reg, dcnt_next;
  logic [HW-1:0] hcnt_reg, hcnt_next;
  logic          long_fired_reg, long_fired_next;
  logic          level_reg, level_next;
  logic          rise_reg, rise_next;
  logic          fall_reg, fall_next;
  logic          long_reg, long_next;
  logic [7:0]    cnt_reg, cnt_next;

  // Polarity is normalised before the first flop so the FSM always sees 1 = pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= sw ^ ACTIVE_LOW;
      s2_reg <= s1_reg;
    end
  end

  always_comb begin
    state_next      = state_reg;
    dcnt_next       = dcnt_reg;
    hcnt_next       = hcnt_reg;
    long_fired_next = long_fired_reg;
    level_next      = level_reg;
    cnt_next        = cnt_reg;
    rise_next       = 1'b0;
    fall_next       = 1'b0;
    long_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (s2_reg) begin
          state_next = ARMING;
          dcnt_next  = DW'(1);
        end
      end

      ARMING: begin
        if (!s2_reg) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else if (dcnt_reg == DEB_LAST) begin
          state_next      = PRESSED;
          dcnt_next       = '0;
          level_next      = 1'b1;
          rise_next       = 1'b1;
          cnt_next        = cnt_reg + 8'd1;
          hcnt_next       = '0;
          long_fired_next = 1'b0;
        end else if (dcnt_reg < DEB_LAST) begin
          dcnt_next = dcnt_reg + DW'(1);
        end
      end

      PRESSED: begin
        // The hold timer parks at its threshold; the flag limits BTN_LONG to one per press.
        if (hcnt_reg < HOLD_LAST) begin
          hcnt_next = hcnt_reg + HW'(1);
        end else if (!long_fired_reg) begin
          long_next       = 1'b1;
          long_fired_next = 1'b1;
        end
        if (!s2_reg) begin
          state_next = DISARMING;
          dcnt_next  = DW'(1);
        end
      end

      DISARMING: begin
        // hcnt is left untouched here so a release bounce resumes the hold timer.
        if (s2_reg) begin
          state_next = PRESSED;
          dcnt_next  = '0;
        end else if (dcnt_reg == DEB_LAST) begin
          state_next = IDLE;
          dcnt_next  = '0;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else if (dcnt_reg < DEB_LAST) begin
          dcnt_next = dcnt_reg + DW'(1);
        end
      end

      default: begin
        state_next = IDLE;
        dcnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      dcnt_reg       <= '0;
      hcnt_reg       <= '0;
      long_fired_reg <= 1'b0;
      level_reg      <= 1'b0;
      rise_reg       <= 1'b0;
      fall_reg       <= 1'b0;
      long_reg       <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      dcnt_reg       <= dcnt_next;
      hcnt_reg       <= hcnt_next;
      long_fired_reg <= long_fired_next;
      level_reg      <= level_next;
      rise_reg       <= rise_next;
      fall_reg       <= fall_next;
      long_reg       <= long_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign btn_level = level_reg;
  assign btn_rise  = rise_reg;
  assign btn_fall  = fall_reg;
  assign btn_long  = long_reg;
  assign press_cnt = cnt_reg;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream front-end for the LED blink block. Conditions the raw push-button SW2 into clean signals:
  - a debounced level,
  - single-cycle rise, fall and long-press pulses,
  - a wrapping press counter.
- Sits between the board pin and LED_blink. LED_blink consumes BTN_RISE or BTN_LONG as its clean trigger, not the raw switch.

Parameters:
- DEBOUNCE_CYCLES, 60000: consecutive identical synchronized samples needed to accept a change. 60000 is 5 ms at 12 MHz. Range 2..2^20.
- HOLD_CYCLES, 12000000: cycles in the accepted-pressed state before BTN_LONG fires. Must be greater than DEBOUNCE_CYCLES.
- ACTIVE_LOW, 0: 1 means the button reads 0 when pressed; SW is inverted before synchronization.

Ports:
- CLK  input  1  system clock; all flops on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- SW  input  1  raw, asynchronous, bouncing button pin.
- BTN_LEVEL  output  1  debounced pressed level.
- BTN_RISE  output  1  one-cycle pulse on an accepted press.
- BTN_FALL  output  1  one-cycle pulse on an accepted release.
- BTN_LONG  output  1  one-cycle pulse, at most once per press, after HOLD_CYCLES pressed.
- PRESS_CNT  output  8  count of accepted presses; wraps 255 -> 0.

Behaviour:
- Reset:
  - While RST_N=0, all flops clear immediately, independent of CLK.
  - Reset clears: sync stages, FSM (goes to IDLE), debounce counter, hold counter, long-fired flag, and all outputs.
  - Outputs are all 0 during reset, and PRESS_CNT=0.
  - Release of RST_N is sampled by the internal synchronizer only; no reset synchronizer is inside this block.
- Synchronizer: 2-FF chain, s1 then s2. ACTIVE_LOW inversion is applied before s1. The FSM uses only s2.
- Debounce counter width: clog2(DEBOUNCE_CYCLES+1). Hold counter width: clog2(HOLD_CYCLES+1). Both saturate and never wrap.
- FSM states:
  - IDLE (BTN_LEVEL=0):
    - s2=1 -> go to ARMING, dcnt=1.
  - ARMING (BTN_LEVEL=0):
    - s2=0 -> back to IDLE, dcnt=0 (bounce rejected).
    - s2=1 and dcnt==DEBOUNCE_CYCLES-1 -> go to PRESSED. Registered effects: BTN_LEVEL=1, BTN_RISE=1 for one cycle, PRESS_CNT+1 mod 256, hcnt=0, long flag cleared.
    - Otherwise dcnt+1.
  - PRESSED (BTN_LEVEL=1):
    - hcnt increments every cycle.
    - When hcnt reaches HOLD_CYCLES-1 and the long flag is 0: BTN_LONG=1 for one cycle, set the long flag, hcnt saturates.
    - s2=0 -> go to DISARMING, dcnt=1. hcnt freezes.
  - DISARMING (BTN_LEVEL=1):
    - s2=1 -> back to PRESSED, dcnt=0. hcnt resumes without clearing, so a bounce cannot restart or repeat BTN_LONG.
    - s2=0 and dcnt==DEBOUNCE_CYCLES-1 -> go to IDLE. Registered effects: BTN_LEVEL=0, BTN_FALL=1 for one cycle.
    - Otherwise dcnt+1.
- Latency: if SW is first sampled high into s1 at edge n and stays high, BTN_LEVEL and BTN_RISE become 1 right after edge n+DEBOUNCE_CYCLES+1. Release latency is symmetric, driving BTN_FALL.
- Pulse exclusivity:
  - BTN_RISE and BTN_FALL are never high in the same cycle.
  - BTN_LONG is never high in the same cycle as BTN_RISE.
  - BTN_LONG may coincide with the DISARMING transition. It can never coincide with BTN_FALL, because hcnt is frozen in DISARMING.
- Glitch rejection: a pulse on SW shorter than DEBOUNCE_CYCLES synchronized cycles causes no output change.
- Reset mid-operation (e.g. in ARMING or PRESSED): everything returns to IDLE with no pulse emitted. After release, a still-held button must be fully re-debounced, producing a fresh BTN_RISE.
- All outputs are registered; there are no combinational paths from SW.

Test Plan:
- Setup for all tests: DEBOUNCE_CYCLES=8, HOLD_CYCLES=40, 10 ns clock, RST_N low for 30 ns.
- Reset check: during and immediately after reset, all outputs are 0 and PRESS_CNT=0. Assert RST_N=0 mid-PRESSED -> BTN_LEVEL drops within 1 ns, and no BTN_FALL pulse occurs.
- Clean press: SW high for 500 ns, then low -> BTN_RISE is one cycle wide, 9 edges after SW is first sampled. PRESS_CNT=1. BTN_FALL is one cycle, 9 edges after release. BTN_LONG asserted exactly once, 40 cycles after BTN_RISE.
- Bounce: SW toggles with 30 ns high / 20 ns low for 200 ns, then holds high -> exactly one BTN_RISE, PRESS_CNT=1, no BTN_FALL.
- Glitch: a 60 ns high pulse (6 cycles) on SW -> no output changes at all.
- Release bounce near hold: drop SW low for 3 cycles at hcnt=35, then hold high -> no BTN_FALL, a single BTN_LONG (on reaching hold threshold), never repeated.
- Wrap: 256 clean presses -> PRESS_CNT returns to 0 after the 256th. ACTIVE_LOW=1 with the inverted stimulus gives identical pulses.
